// File: rtl/fp_addsub_pipe_if.sv
// ============================================================================
// fp_addsub_pipe_if
// ----------------------------------------------------------------------------
// Operand/result bundle for the pipelined floating-point adder/subtractor.
// It groups the input handshake, the operands, the output handshake, the
// result and its status flags.
//
// Modports:
//   master - producer/consumer side (drives operands and out_ready)
//   slave  - the adder itself (drives in_ready, result and flags)
//
// Signals (W = 1 + EXPONENT_WIDTH + MANTISSA_WIDTH):
//   in_valid, in_ready    operand pair handshake
//   op_sub                0 = A+B, 1 = A-B
//   A_FP, B_FP [W]        packed {sign, exponent, mantissa}
//   out_valid, out_ready  result handshake
//   result [W]            packed sum
//   flag_overflow         finite inputs saturated to infinity
//   flag_underflow        nonzero exact result flushed to zero
//   flag_invalid          NaN produced
// ============================================================================
interface fp_addsub_pipe_if #(
    parameter int EXPONENT_WIDTH = 8,
    parameter int MANTISSA_WIDTH = 23
);
    localparam int W = 1 + EXPONENT_WIDTH + MANTISSA_WIDTH;

    logic         in_valid;
    logic         in_ready;
    logic         op_sub;
    logic [W-1:0] A_FP;
    logic [W-1:0] B_FP;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         flag_overflow;
    logic         flag_underflow;
    logic         flag_invalid;

    modport master (
        output in_valid, op_sub, A_FP, B_FP, out_ready,
        input  in_ready, out_valid, result,
               flag_overflow, flag_underflow, flag_invalid
    );

    modport slave (
        input  in_valid, op_sub, A_FP, B_FP, out_ready,
        output in_ready, out_valid, result,
               flag_overflow, flag_underflow, flag_invalid
    );
endinterface

// File: rtl/fp_addsub_pipe.sv
// ============================================================================
// fp_addsub_pipe
// ----------------------------------------------------------------------------
// Four-stage pipelined floating-point adder/subtractor with valid/ready
// handshake and a global stall. Denormal inputs are flushed to zero, tiny
// results are flushed to signed zero, and infinities/NaNs are handled with a
// canonical quiet NaN.
//
//   S1: unpack, apply op_sub to B, order operands so |X| >= |Y|, exp diff
//   S2: align Y with guard/round/sticky
//   S3: add/subtract magnitudes, leading-zero count, normalise
//   S4: round, exponent adjust, overflow/underflow/special override, pack
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    fp_addsub_pipe_if.slave (operands, result, flags, handshakes)
//
// Configuration:
//   FP_ADDSUB_RNE_EN  defined   -> round to nearest, ties to even
//                     undefined -> truncate toward zero (no incrementer)
// ============================================================================
module fp_addsub_pipe #(
    parameter int EXPONENT_WIDTH = 8,
    parameter int MANTISSA_WIDTH = 23
) (
    input  logic               clk,
    input  logic               rst_n,
    fp_addsub_pipe_if.slave    bus
);
    localparam int EW  = EXPONENT_WIDTH;
    localparam int MW  = MANTISSA_WIDTH;
    localparam int W   = 1 + EW + MW;
    localparam int SW  = MW + 4;          // hidden bit + fraction + G/R/S
    localparam int XW  = EW + 2;          // signed exponent with headroom
    localparam int LZW = $clog2(SW + 1);

    localparam logic [EW-1:0] EXP_ONES    = '1;
    localparam logic [W-1:0]  QNAN        = {1'b0, EXP_ONES, 1'b1, {(MW-1){1'b0}}};
    localparam logic [31:0]   ALIGN_LIMIT = 32'(MW + 3);

    // Global stall: every stage moves together or not at all.
    logic advance;
    logic outValid_q;

    assign advance      = !outValid_q || bus.out_ready;
    assign bus.in_ready = advance;

    // ------------------------------------------------------------------------
    // Stage 1
    // ------------------------------------------------------------------------
    logic            aSign, bSign, aZero, bZero, aNan, bNan, aInf, bInf, swap;
    logic [EW-1:0]   aExp, bExp;
    logic [MW-1:0]   aMan, bMan;
    logic [MW:0]     aSig, bSig;
    logic [EW+MW-1:0] aMag, bMag;

    logic            s1Valid_d, s1SignX_d, s1SignY_d, s1Special_d, s1Invalid_d;
    logic [EW-1:0]   s1ExpX_d, s1Diff_d;
    logic [MW:0]     s1SigX_d, s1SigY_d;
    logic [W-1:0]    s1SpecialRes_d;

    logic            s1Valid_q, s1SignX_q, s1SignY_q, s1Special_q, s1Invalid_q;
    logic [EW-1:0]   s1ExpX_q, s1Diff_q;
    logic [MW:0]     s1SigX_q, s1SigY_q;
    logic [W-1:0]    s1SpecialRes_q;

    // Unpack both operands, flush denormals, order by magnitude and decide
    // early whether an infinity/NaN rule overrides the arithmetic result.
    always_comb begin
        aSign = bus.A_FP[W-1];
        aExp  = bus.A_FP[W-2:MW];
        aMan  = bus.A_FP[MW-1:0];
        bSign = bus.B_FP[W-1] ^ bus.op_sub;
        bExp  = bus.B_FP[W-2:MW];
        bMan  = bus.B_FP[MW-1:0];

        aZero = (aExp == '0);
        bZero = (bExp == '0);
        aNan  = (aExp == EXP_ONES) && (aMan != '0);
        bNan  = (bExp == EXP_ONES) && (bMan != '0);
        aInf  = (aExp == EXP_ONES) && (aMan == '0);
        bInf  = (bExp == EXP_ONES) && (bMan == '0);

        aSig  = aZero ? {(MW+1){1'b0}} : {1'b1, aMan};
        bSig  = bZero ? {(MW+1){1'b0}} : {1'b1, bMan};
        aMag  = {aExp, aSig[MW-1:0]};
        bMag  = {bExp, bSig[MW-1:0]};
        swap  = (bMag > aMag);

        s1Valid_d = bus.in_valid;
        s1SignX_d = swap ? bSign : aSign;
        s1SignY_d = swap ? aSign : bSign;
        s1ExpX_d  = swap ? bExp : aExp;
        s1SigX_d  = swap ? bSig : aSig;
        s1SigY_d  = swap ? aSig : bSig;
        s1Diff_d  = swap ? (bExp - aExp) : (aExp - bExp);

        s1Special_d    = 1'b0;
        s1Invalid_d    = 1'b0;
        s1SpecialRes_d = '0;
        if (aNan || bNan) begin
            s1Special_d    = 1'b1;
            s1Invalid_d    = 1'b1;
            s1SpecialRes_d = QNAN;
        end else if (aInf && bInf) begin
            s1Special_d = 1'b1;
            if (aSign != bSign) begin
                s1Invalid_d    = 1'b1;
                s1SpecialRes_d = QNAN;
            end else begin
                s1SpecialRes_d = {aSign, EXP_ONES, {MW{1'b0}}};
            end
        end else if (aInf) begin
            s1Special_d    = 1'b1;
            s1SpecialRes_d = {aSign, EXP_ONES, {MW{1'b0}}};
        end else if (bInf) begin
            s1Special_d    = 1'b1;
            s1SpecialRes_d = {bSign, EXP_ONES, {MW{1'b0}}};
        end
    end

    // Stage 1 register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1Valid_q      <= 1'b0;
            s1SignX_q      <= 1'b0;
            s1SignY_q      <= 1'b0;
            s1ExpX_q       <= '0;
            s1Diff_q       <= '0;
            s1SigX_q       <= '0;
            s1SigY_q       <= '0;
            s1Special_q    <= 1'b0;
            s1Invalid_q    <= 1'b0;
            s1SpecialRes_q <= '0;
        end else if (advance) begin
            s1Valid_q      <= s1Valid_d;
            s1SignX_q      <= s1SignX_d;
            s1SignY_q      <= s1SignY_d;
            s1ExpX_q       <= s1ExpX_d;
            s1Diff_q       <= s1Diff_d;
            s1SigX_q       <= s1SigX_d;
            s1SigY_q       <= s1SigY_d;
            s1Special_q    <= s1Special_d;
            s1Invalid_q    <= s1Invalid_d;
            s1SpecialRes_q <= s1SpecialRes_d;
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2
    // ------------------------------------------------------------------------
    logic [SW-1:0] extY, shiftedY, lostMask;
    logic          lostSticky;

    logic          s2Valid_d, s2Sign_d, s2EffSub_d;
    logic [EW-1:0] s2Exp_d;
    logic [SW-1:0] s2SigX_d, s2SigY_d;

    logic          s2Valid_q, s2Sign_q, s2EffSub_q, s2Special_q, s2Invalid_q;
    logic [EW-1:0] s2Exp_q;
    logic [SW-1:0] s2SigX_q, s2SigY_q;
    logic [W-1:0]  s2SpecialRes_q;

    // Align the smaller operand. Every bit shifted past the sticky position
    // is ORed into sticky so rounding still sees that something was lost.
    always_comb begin
        extY       = {s1SigY_q, 3'b000};
        shiftedY   = extY >> s1Diff_q;
        lostMask   = ~({SW{1'b1}} << s1Diff_q);
        lostSticky = |(extY & lostMask);

        if (32'(s1Diff_q) >= ALIGN_LIMIT) begin
            s2SigY_d = {{(SW-1){1'b0}}, |s1SigY_q};
        end else begin
            s2SigY_d = {shiftedY[SW-1:1], shiftedY[0] | lostSticky};
        end

        s2Valid_d  = s1Valid_q;
        s2Sign_d   = s1SignX_q;
        s2EffSub_d = s1SignX_q ^ s1SignY_q;
        s2Exp_d    = s1ExpX_q;
        s2SigX_d   = {s1SigX_q, 3'b000};
    end

    // Stage 2 register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2Valid_q      <= 1'b0;
            s2Sign_q       <= 1'b0;
            s2EffSub_q     <= 1'b0;
            s2Exp_q        <= '0;
            s2SigX_q       <= '0;
            s2SigY_q       <= '0;
            s2Special_q    <= 1'b0;
            s2Invalid_q    <= 1'b0;
            s2SpecialRes_q <= '0;
        end else if (advance) begin
            s2Valid_q      <= s2Valid_d;
            s2Sign_q       <= s2Sign_d;
            s2EffSub_q     <= s2EffSub_d;
            s2Exp_q        <= s2Exp_d;
            s2SigX_q       <= s2SigX_d;
            s2SigY_q       <= s2SigY_d;
            s2Special_q    <= s1Special_q;
            s2Invalid_q    <= s1Invalid_q;
            s2SpecialRes_q <= s1SpecialRes_q;
        end
    end

    // ------------------------------------------------------------------------
    // Stage 3
    // ------------------------------------------------------------------------
    function automatic logic [LZW-1:0] countLeadingZeros(input logic [SW-1:0] v);
        logic [LZW-1:0] n;
        logic           found;
        n     = '0;
        found = 1'b0;
        for (int i = SW - 1; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      n     = n + LZW'(1);
            end
        end
        return n;
    endfunction

    logic [SW:0]           sumMag;
    logic [LZW-1:0]        lzc;

    logic                  s3Sign_d;
    logic [SW-1:0]         s3Norm_d;
    logic signed [XW-1:0]  s3Exp_d;

    logic                  s3Valid_q, s3Sign_q, s3Special_q, s3Invalid_q;
    logic [SW-1:0]         s3Norm_q;
    logic signed [XW-1:0]  s3Exp_q;
    logic [W-1:0]          s3SpecialRes_q;

    // X is never smaller than Y, so the difference cannot go negative.
    // A carry-out shifts right by one (folding the lost bit into sticky);
    // otherwise the leading one is brought back to the hidden-bit position.
    // An exact zero from a true subtraction is +0; -0 + -0 keeps its sign.
    always_comb begin
        if (s2EffSub_q) sumMag = {1'b0, s2SigX_q} - {1'b0, s2SigY_q};
        else            sumMag = {1'b0, s2SigX_q} + {1'b0, s2SigY_q};

        lzc = countLeadingZeros(sumMag[SW-1:0]);

        if (sumMag[SW]) begin
            s3Norm_d = {sumMag[SW:2], sumMag[1] | sumMag[0]};
            s3Exp_d  = XW'(s2Exp_q) + XW'(1);
        end else begin
            s3Norm_d = sumMag[SW-1:0] << lzc;
            s3Exp_d  = XW'(s2Exp_q) - XW'(lzc);
        end

        s3Sign_d = ((sumMag == '0) && s2EffSub_q) ? 1'b0 : s2Sign_q;
    end

    // Stage 3 register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3Valid_q      <= 1'b0;
            s3Sign_q       <= 1'b0;
            s3Norm_q       <= '0;
            s3Exp_q        <= '0;
            s3Special_q    <= 1'b0;
            s3Invalid_q    <= 1'b0;
            s3SpecialRes_q <= '0;
        end else if (advance) begin
            s3Valid_q      <= s2Valid_q;
            s3Sign_q       <= s3Sign_d;
            s3Norm_q       <= s3Norm_d;
            s3Exp_q        <= s3Exp_d;
            s3Special_q    <= s2Special_q;
            s3Invalid_q    <= s2Invalid_q;
            s3SpecialRes_q <= s2SpecialRes_q;
        end
    end

    // ------------------------------------------------------------------------
    // Stage 4
    // ------------------------------------------------------------------------
    logic                  normZero;
    logic [MW-1:0]         frac;
    logic signed [XW-1:0]  expR;
`ifdef FP_ADDSUB_RNE_EN
    logic                  roundUp;
    logic [MW:0]           fracRounded;
`endif

    logic         outValid_d, ovf_d, unf_d, inv_d;
    logic [W-1:0] result_d;
    logic         ovf_q, unf_q, inv_q;
    logic [W-1:0] result_q;

    // The normalised significand is zero only for an exact zero sum.
    // Rounding happens before the range checks so a rounding carry can
    // still push the result into overflow.
    always_comb begin
        normZero = (s3Norm_q == '0);
`ifdef FP_ADDSUB_RNE_EN
        roundUp     = s3Norm_q[2] & (s3Norm_q[1] | s3Norm_q[0] | s3Norm_q[3]);
        fracRounded = {1'b0, s3Norm_q[SW-2:3]} + (MW+1)'(roundUp);
        frac        = fracRounded[MW-1:0];
        expR        = s3Exp_q + XW'(fracRounded[MW]);
`else
        frac        = s3Norm_q[SW-2:3];
        expR        = s3Exp_q;
`endif

        outValid_d = s3Valid_q;
        ovf_d      = 1'b0;
        unf_d      = 1'b0;
        inv_d      = 1'b0;
        result_d   = '0;

        if (s3Special_q) begin
            result_d = s3SpecialRes_q;
            inv_d    = s3Invalid_q;
        end else if (normZero) begin
            result_d = {s3Sign_q, {(W-1){1'b0}}};
        end else if (expR >= $signed(XW'(EXP_ONES))) begin
            result_d = {s3Sign_q, EXP_ONES, {MW{1'b0}}};
            ovf_d    = 1'b1;
        end else if (expR <= $signed(XW'(0))) begin
            result_d = {s3Sign_q, {(W-1){1'b0}}};
            unf_d    = 1'b1;
        end else begin
            result_d = {s3Sign_q, expR[EW-1:0], frac};
        end
    end

    // Output register: result and flags always travel together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outValid_q <= 1'b0;
            result_q   <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            inv_q      <= 1'b0;
        end else if (advance) begin
            outValid_q <= outValid_d;
            result_q   <= result_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            inv_q      <= inv_d;
        end
    end

    assign bus.out_valid      = outValid_q;
    assign bus.result         = result_q;
    assign bus.flag_overflow  = ovf_q;
    assign bus.flag_underflow = unf_q;
    assign bus.flag_invalid   = inv_q;

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// ============================================================================
// tb_fp_addsub_pipe
// ----------------------------------------------------------------------------
// Self-checking bench for fp_addsub_pipe (single precision). Expected results
// are hand-derived constants queued when an operand pair is accepted and
// compared, in order, when the result is taken. The tag packs the flags as
// {overflow, underflow, invalid, result}.
// ============================================================================
module tb_fp_addsub_pipe;

    logic clk;
    logic rst_n;

    fp_addsub_pipe_if #(.EXPONENT_WIDTH(8), .MANTISSA_WIDTH(23)) bus ();

    fp_addsub_pipe #(.EXPONENT_WIDTH(8), .MANTISSA_WIDTH(23)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [34:0] expected;
    } vec_t;

    typedef struct {
        string       name;
        logic [34:0] value;
        int          issueCycle;
        bit          timed;
    } expect_t;

    vec_t        vecs[$];
    expect_t     q[$];
    int          checks     = 0;
    int          failures   = 0;
    int          cycleCnt   = 0;
    int          stallCount = 0;
    int          popCount   = 0;
    logic [34:0] observed;

    assign observed = {bus.flag_overflow, bus.flag_underflow, bus.flag_invalid, bus.result};

    // Free-running clock and cycle counter used for latency measurement.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Present one operand pair, hold it until accepted, queue its expectation.
    task automatic applyStimulus(input string name, input logic [31:0] a, input logic [31:0] b,
                                 input logic sub, input logic [34:0] expected, input bit timed);
        int budget;
        bit done;
        budget = 0;
        done   = 1'b0;
        bus.A_FP     = a;
        bus.B_FP     = b;
        bus.op_sub   = sub;
        bus.in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (bus.in_ready) begin
                q.push_back('{name, expected, cycleCnt, timed});
                done = 1'b1;
            end else if (++budget > 50) begin
                checkOutput({"acceptTimeout_", name}, 64'(bus.in_ready), 64'(1));
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
    endtask

    // Wait (bounded) until every queued expectation has been consumed.
    task automatic waitDrain(input string tag);
        int budget;
        budget = 0;
        while (q.size() != 0 && budget < 100) begin
            @(posedge clk);
            budget++;
        end
        #1;
        checkOutput(tag, 64'(q.size()), 64'(0));
    endtask

    // Output monitor: pop and compare on each transfer, and while stalled
    // check that the pending result is held and input is blocked.
    always @(negedge clk) begin
        expect_t e;
        if (rst_n && bus.out_valid) begin
            if (bus.out_ready) begin
                if (q.size() == 0) begin
                    checkOutput("spuriousOutput", 64'(q.size()), 64'(1));
                end else begin
                    e = q.pop_front();
                    popCount++;
                    checkOutput(e.name, 64'(observed), 64'(e.value));
                    if (e.timed)
                        checkOutput({"latency_", e.name}, 64'(cycleCnt - e.issueCycle), 64'(4));
                end
            end else begin
                stallCount++;
                checkOutput("stallInReady", 64'(bus.in_ready), 64'(0));
                if (q.size() != 0)
                    checkOutput({"stallHold_", q[0].name}, 64'(observed), 64'(q[0].value));
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence.
    initial begin
        int startPops;

        vecs.push_back('{"add",        32'h40E80000, 32'h3EC00000, 1'b0, 35'h0_40F40000});
        vecs.push_back('{"sub65m63",   32'h42820000, 32'h427C0000, 1'b1, 35'h0_40000000});
        vecs.push_back('{"cancel",     32'h40800000, 32'h40800000, 1'b1, 35'h0_00000000});
        vecs.push_back('{"overflow",   32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 35'h4_7F800000});
        vecs.push_back('{"infMinusInf",32'h7F800000, 32'hFF800000, 1'b0, 35'h1_7FC00000});
        vecs.push_back('{"denormFlush",32'h00000001, 32'h00000000, 1'b0, 35'h0_00000000});
`ifdef FP_ADDSUB_RNE_EN
        vecs.push_back('{"roundTie",   32'h3F800001, 32'h33800000, 1'b0, 35'h0_3F800002});
`else
        vecs.push_back('{"roundTie",   32'h3F800001, 32'h33800000, 1'b0, 35'h0_3F800001});
`endif
        vecs.push_back('{"negZeros",   32'h80000000, 32'h80000000, 1'b0, 35'h0_80000000});
        vecs.push_back('{"mixedZeros", 32'h80000000, 32'h00000000, 1'b0, 35'h0_00000000});
        vecs.push_back('{"swapSub",    32'h3F800000, 32'h40400000, 1'b1, 35'h0_C0000000});
        vecs.push_back('{"mixedSign",  32'h3FC00000, 32'hBF000000, 1'b0, 35'h0_3F800000});
        vecs.push_back('{"infMinusFin",32'hFF800000, 32'h3F800000, 1'b1, 35'h0_FF800000});
        vecs.push_back('{"nanInput",   32'h7F800001, 32'h3F800000, 1'b0, 35'h1_7FC00000});
        vecs.push_back('{"tieEven",    32'h4B800000, 32'h3F800000, 1'b0, 35'h0_4B800000});
        vecs.push_back('{"stickyOnly", 32'h3F800000, 32'h00800000, 1'b0, 35'h0_3F800000});
        vecs.push_back('{"underflow",  32'h00800001, 32'h00800000, 1'b1, 35'h2_00000000});
        vecs.push_back('{"onePlusOne", 32'h3F800000, 32'h3F800000, 1'b0, 35'h0_40000000});

        bus.in_valid  = 1'b0;
        bus.op_sub    = 1'b0;
        bus.A_FP      = '0;
        bus.B_FP      = '0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;

        // Reset state.
        #1;
        checkOutput("rstOutValid", 64'(bus.out_valid), 64'(0));
        checkOutput("rstResult",   64'(observed),      64'(0));
        checkOutput("rstInReady",  64'(bus.in_ready),  64'(1));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors streamed back to back with out_ready high.
        $display("[TB] directed vectors");
        foreach (vecs[i])
            applyStimulus(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].expected, 1'b1);
        waitDrain("drainDirected");

        // Six back-to-back ops with a three-cycle output stall mid-stream.
        $display("[TB] backpressure stream");
        stallCount = 0;
        startPops  = popCount;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    applyStimulus({"bp_", vecs[i].name}, vecs[i].a, vecs[i].b, vecs[i].sub,
                                  vecs[i].expected, 1'b0);
            end
            begin
                repeat (5) @(posedge clk);
                #1 bus.out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        waitDrain("drainStream");
        checkOutput("stallCycles", 64'(stallCount), 64'(3));
        checkOutput("streamCount", 64'(popCount - startPops), 64'(6));

        // Reset with operations in flight.
        $display("[TB] reset mid-flight");
        for (int i = 0; i < 3; i++)
            applyStimulus({"rst_", vecs[i].name}, vecs[i].a, vecs[i].b, vecs[i].sub,
                          vecs[i].expected, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("preResetValid", 64'(bus.out_valid), 64'(1));
        rst_n = 1'b0;
        q.delete();
        #1;
        checkOutput("midRstOutValid", 64'(bus.out_valid), 64'(0));
        checkOutput("midRstResult",   64'(observed),      64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("postRstIdle", 64'(bus.out_valid), 64'(0));
        applyStimulus("postRstAdd", vecs[0].a, vecs[0].b, vecs[0].sub, vecs[0].expected, 1'b1);
        waitDrain("drainPostReset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_addsub_pipe.md
Name: fp_addsub_pipe

Overview:
- Parametrised, pipelined IEEE-754-style floating-point adder/subtractor; successor to the single-format combinational/registered fp adder.
- Adds an add/sub mode, a valid/ready handshake with backpressure, special-value handling, status flags and selectable rounding.
- Sits in the CNN datapath behind the multiplier array as the accumulate/bias-add unit.

Parameters:
- EXPONENT_WIDTH, 8, exponent field width; bias = 2^(EXPONENT_WIDTH-1)-1.
- MANTISSA_WIDTH, 23, stored fraction width; the hidden bit is implicit.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block accepts an operand pair this cycle.
- op_sub  in  1  0 = A+B, 1 = A-B; sampled with operands.
- A_FP  in  W  operand A, packed {sign, exponent, mantissa}; W = 1+EXPONENT_WIDTH+MANTISSA_WIDTH.
- B_FP  in  W  operand B, same packing.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  W  packed sum.
- flag_overflow  out  1  result saturated to infinity from finite inputs.
- flag_underflow  out  1  nonzero exact result flushed to zero.
- flag_invalid  out  1  NaN produced (NaN input, or inf-inf).

Behaviour:
- Reset (async, rst_n=0): all stage valid bits = 0; out_valid=0, result=0, all flags=0. in_ready=1 during and after reset.
- Reset mid-operation discards every in-flight result. No output appears for operands accepted before reset.
- Four register stages:
  - S1: unpack, apply op_sub to B's sign, swap so |X|>=|Y|, compute exponent difference.
  - S2: align Y by right shift, keeping guard/round/sticky; shifts >= MANTISSA_WIDTH+3 collapse Y to sticky only.
  - S3: add/subtract magnitudes; leading-zero count; normalise (left shift, or right shift by 1 on carry-out).
  - S4: round, exponent adjust, overflow/underflow/special override, pack.
- Latency: 4 cycles from accept to out_valid with out_ready held high. Throughput: 1 op/cycle.
- Handshake:
  - Transfer occurs when valid&ready are both high.
  - Global stall: advance = !out_valid | out_ready; in_ready = advance.
  - While stalled, all stage registers hold and result/flags stay stable.
  - Bubbles are not compressed.
  - No results are lost or reordered.
- Input and output zero/denormal handling:
  - Exponent 0 is treated as signed zero; denormals are flushed on input.
  - A result exponent <= 0 after rounding gives signed zero; flag_underflow=1 if the exact result was nonzero.
- Exact-zero result sign:
  - Exact cancellation (x + -x) gives +0.
  - -0 + -0 gives -0.
- Special values (exponent all ones):
  - inf±finite gives that inf.
  - inf+inf of the same sign gives inf.
  - inf-inf gives canonical qNaN with flag_invalid=1.
  - Any NaN input gives canonical qNaN with flag_invalid=1.
  - Canonical qNaN = sign 0, exponent all ones, mantissa MSB 1 and all other mantissa bits 0.
- Overflow: a result exponent >= all-ones from finite inputs gives signed infinity with flag_overflow=1.
- Flags accompany their result and are valid only while out_valid=1.

Optional Feature:
- Macro FP_ADDSUB_RNE_EN.
- Defined: round-to-nearest, ties-to-even, using guard/round/sticky. A mantissa carry from rounding increments the exponent and may trigger overflow.
- Undefined: truncation toward zero. Guard/round/sticky are discarded, and S4 contains no rounding incrementer (same 4-cycle latency).

Test Plan:
- Add: A=0x40E80000 (7.25), B=0x3EC00000 (0.375), op_sub=0 -> result 0x40F40000 (7.625), 4 cycles after accept, flags 0.
- Subtract and cancellation:
  - op_sub=1, A=0x42820000 (65), B=0x427C0000 (63) -> 0x40000000 (2).
  - op_sub=1, A=B=0x40800000 (4) -> 0x00000000 (+0).
- Specials and overflow:
  - 0x7F7FFFFF+0x7F7FFFFF -> 0x7F800000, flag_overflow=1.
  - 0x7F800000+0xFF800000 -> 0x7FC00000, flag_invalid=1.
  - 0x00000001 (denormal)+0 -> 0x00000000.
- Rounding: 0x3F800001+0x33800000 -> 0x3F800002 with FP_ADDSUB_RNE_EN defined; 0x3F800001 without it.
- Backpressure: stream 6 back-to-back ops, hold out_ready=0 for 3 cycles mid-stream.
  - in_ready drops the same cycle.
  - result is held stable.
  - All 6 results emerge in order, no duplicates.
- Reset mid-flight: accept 3 ops, assert rst_n=0 for 1 cycle.
  - out_valid=0 immediately.
  - No stale results after release.
  - A new op completes in 4 cycles.
